// File: rtl/carrier_lock_ctrl_if.sv
// Sample input and lock-status bundle for the carrier lock controller.
// The master side feeds samples and restart; the slave side reports lock state.
interface carrier_lock_ctrl_if;
  logic               din_valid;
  logic signed [25:0] pd;
  logic               restart;
  logic [1:0]         state;
  logic [1:0]         gain_sel;
  logic signed [31:0] sweep;
  logic               locked;
  logic               win_done;
  logic [25:0]        metric;

  modport master (
    output din_valid, pd, restart,
    input  state, gain_sel, sweep, locked, win_done, metric
  );

  modport slave (
    input  din_valid, pd, restart,
    output state, gain_sel, sweep, locked, win_done, metric
  );
endinterface

// File: rtl/carrier_lock_ctrl.sv
// Carrier lock controller: averages |pd| over fixed windows and steps a
// SEARCH/ACQ/TRACK/HOLD machine that drives the NCO sweep and loop gain.
module carrier_lock_ctrl #(
  parameter int WIN_LOG2   = 10,
  parameter int ACQ_TH     = 1 << 20,
  parameter int LOCK_TH    = 1 << 18,
  parameter int UNLOCK_TH  = 1 << 19,
  parameter int LOCK_CNT   = 4,
  parameter int LOSS_CNT   = 2,
  parameter int SWEEP_STEP = 4096,
  parameter int SWEEP_MAX  = 1 << 20
) (
  input logic                clk,
  input logic                rst,
  carrier_lock_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ACQ    = 2'd1,
    TRACK  = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int          ACC_W    = 26 + WIN_LOG2;
  localparam logic [25:0] ACQ_T    = 26'(ACQ_TH);
  localparam logic [25:0] LOCK_T   = 26'(LOCK_TH);
  localparam logic [25:0] UNLOCK_T = 26'(UNLOCK_TH);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0]  LOSS_N   = 4'(LOSS_CNT);

  logic [25:0]         mag;
  logic [ACC_W-1:0]    acc, acc_sum;
  logic [WIN_LOG2-1:0] cnt;
  logic                last;
  logic [25:0]         metric_q;
  logic                win_done_q;

  state_t             state_q, state_nxt;
  logic signed [31:0] sweep_q, sweep_nxt;
  logic signed [32:0] sweep_inc;
  logic [3:0]         good_q, good_nxt, good_inc;
  logic [3:0]         bad_q, bad_nxt, bad_inc;
  logic [1:0]         gain_q;
  logic               locked_q;

  function automatic logic [1:0] gain_of(state_t s);
    case (s)
      ACQ, HOLD: gain_of = 2'd1;
      TRACK:     gain_of = 2'd2;
      default:   gain_of = 2'd0;
    endcase
  endfunction

  // -2^25 has no positive twin in 26 bits, so it clips to 2^25-1.
  always_comb begin
    mag = $unsigned(bus.pd);
    if (bus.pd[25]) begin
      if (bus.pd[24:0] == 25'd0) mag = 26'h1FF_FFFF;
      else                       mag = $unsigned(-bus.pd);
    end
  end

  assign acc_sum = acc + {{WIN_LOG2{1'b0}}, mag};
  assign last    = bus.din_valid && (cnt == '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      cnt        <= '0;
      metric_q   <= '0;
      win_done_q <= 1'b0;
    end else if (bus.restart) begin
      acc        <= '0;
      cnt        <= '0;
      win_done_q <= 1'b0;
    end else begin
      win_done_q <= 1'b0;
      if (bus.din_valid) begin
        if (last) begin
          metric_q   <= acc_sum[ACC_W-1:WIN_LOG2];
          acc        <= '0;
          cnt        <= '0;
          win_done_q <= 1'b1;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign sweep_inc = 33'(sweep_q) + 33'(SWEEP_STEP);
  assign good_inc  = good_q + 4'd1;
  assign bad_inc   = bad_q + 4'd1;

  // The machine only moves on the cycle after a window completes.
  always_comb begin
    state_nxt = state_q;
    sweep_nxt = sweep_q;
    good_nxt  = good_q;
    bad_nxt   = bad_q;
    if (bus.restart) begin
      state_nxt = SEARCH;
      sweep_nxt = '0;
      good_nxt  = '0;
      bad_nxt   = '0;
    end else if (win_done_q) begin
      case (state_q)
        SEARCH: begin
          if (metric_q >= ACQ_T) begin
            if (sweep_inc > 33'(SWEEP_MAX)) sweep_nxt = 32'(-SWEEP_MAX);
            else                            sweep_nxt = sweep_inc[31:0];
          end else begin
            state_nxt = ACQ;
            good_nxt  = '0;
          end
        end
        ACQ: begin
          if (metric_q < LOCK_T) begin
            if (good_inc == LOCK_N) begin
              state_nxt = TRACK;
              good_nxt  = '0;
              bad_nxt   = '0;
            end else begin
              good_nxt = good_inc;
            end
          end else if (metric_q >= ACQ_T) begin
            state_nxt = SEARCH;
            good_nxt  = '0;
          end else begin
            good_nxt = '0;
          end
        end
        TRACK: begin
          if (metric_q >= UNLOCK_T) begin
            if (bad_inc == LOSS_N) begin
              state_nxt = HOLD;
              bad_nxt   = '0;
            end else begin
              bad_nxt = bad_inc;
            end
          end else begin
            bad_nxt = '0;
          end
        end
        HOLD: begin
          if (metric_q < UNLOCK_T) begin
            state_nxt = TRACK;
            bad_nxt   = '0;
          end else begin
            state_nxt = SEARCH;
            sweep_nxt = '0;
            good_nxt  = '0;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= SEARCH;
      sweep_q  <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      gain_q   <= 2'd0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      sweep_q  <= sweep_nxt;
      good_q   <= good_nxt;
      bad_q    <= bad_nxt;
      gain_q   <= gain_of(state_nxt);
      locked_q <= (state_nxt == TRACK);
    end
  end

  assign bus.state    = state_q;
  assign bus.gain_sel = gain_q;
  assign bus.sweep    = sweep_q;
  assign bus.locked   = locked_q;
  assign bus.win_done = win_done_q;
  assign bus.metric   = metric_q;

endmodule

// File: doc/carrier_lock_ctrl.md
CARRIER_LOCK_CTRL -- requirements
Module: carrier_lock_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WIN_LOG2, 10: log2 of samples per metric window.
- ACQ_TH, 2^20: metric at or above this level means unlocked.
- LOCK_TH, 2^18: metric below this level counts as a good window.
- UNLOCK_TH, 2^19: metric at or above this level counts as a bad window.
- LOCK_CNT, 4: consecutive good windows required to declare lock.
- LOSS_CNT, 2: consecutive bad windows required to declare loss.
- SWEEP_STEP, 4096: frequency sweep increment per window.
- SWEEP_MAX, 2^20: sweep magnitude limit.
REQ-002 Constraint: LOCK_TH < UNLOCK_TH <= ACQ_TH; LOCK_CNT, LOSS_CNT in 1..15.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1: system clock, 8 MHz.
- rst, in, 1: reset, asynchronous, active-low.
- din_valid, in, 1: pd sample strobe.
- pd, in, 26 signed: phase detector output.
- restart, in, 1: synchronous forced re-acquisition.
- state, out, 2: 0 SEARCH, 1 ACQ, 2 TRACK, 3 HOLD.
- gain_sel, out, 2: loop filter bandwidth select (0 wide, 1 medium, 2 narrow).
- sweep, out, 32 signed: NCO frequency offset word.
- locked, out, 1: carrier lock flag.
- win_done, out, 1: one-cycle pulse when metric updates.
- metric, out, 26 unsigned: mean |pd| of the last completed window.

Function
REQ-004 When din_valid=1, the block SHALL take |pd|, saturating -2^25 to 2^25-1, and add it to an accumulator of 26+WIN_LOG2 bits that cannot overflow.
REQ-005 When din_valid=0, the accumulator and the sample counter SHALL hold.
REQ-006 On the cycle the 2^WIN_LOG2-th valid sample is accepted, the block SHALL include that sample, register metric = sum >> WIN_LOG2 (truncated), pulse win_done for exactly one cycle, and clear both the accumulator and the sample counter.
REQ-007 metric and win_done SHALL be valid one clock after the last sample of the window.
REQ-008 State transitions and updates to sweep and the counters SHALL occur only on the clock edge that follows a win_done cycle, using the metric then registered.
REQ-009 Outputs SHALL change one clock after win_done.
REQ-010 SEARCH behaviour:
- gain_sel=0, locked=0.
- If metric >= ACQ_TH: sweep += SWEEP_STEP; if the result would exceed SWEEP_MAX, sweep becomes -SWEEP_MAX (wrap).
- Otherwise: go to ACQ, freeze sweep, good count=0.
REQ-011 ACQ behaviour:
- gain_sel=1, locked=0.
- metric < LOCK_TH: good count increments; when it reaches LOCK_CNT, go to TRACK.
- metric >= ACQ_TH: go to SEARCH, good count=0.
- Any other metric: good count=0, stay in ACQ.
REQ-012 TRACK behaviour:
- gain_sel=2, locked=1.
- metric >= UNLOCK_TH: bad count increments; when it reaches LOSS_CNT, go to HOLD.
- Any other metric: bad count=0.
REQ-013 HOLD behaviour:
- gain_sel=1, locked=0, sweep frozen.
- The next window decides: metric < UNLOCK_TH goes to TRACK with bad count=0; otherwise go to SEARCH with sweep=0.
REQ-014 restart=1 SHALL, on the next clock edge, force SEARCH, sweep=0, both counters=0, accumulator and sample counter=0, and win_done=0.
REQ-015 restart SHALL take priority over a simultaneous window completion; metric SHALL hold its prior value.
REQ-016 gain_sel and locked SHALL be registered and decoded from the next state, so they track state with no extra cycle.
REQ-017 Value 3 on gain_sel is reserved and SHALL never be driven.

Reset
REQ-018 rst=0 SHALL immediately set: state=SEARCH, gain_sel=0, sweep=0, locked=0, win_done=0, metric=0, and all counters and the accumulator to 0.
REQ-019 Reset SHALL be honoured at any point mid-window or mid-state, and the first window after release SHALL start at sample 0.

Verification
All scenarios use bench overrides WIN_LOG2=4, ACQ_TH=500, LOCK_TH=200, UNLOCK_TH=300, LOCK_CNT=4, LOSS_CNT=2, SWEEP_STEP=100, SWEEP_MAX=250.
REQ-020 Reset: assert rst=0 at sample 9 of a window -> all outputs 0 at once. Release and feed 16 samples of pd=1000 -> win_done on cycle 17, metric=1000, and sweep=100 one clock later.
REQ-021 Sweep and gaps: constant pd=-1000 with din_valid toggling every other cycle -> windows complete every 32 cycles; sweep sequence 100, 200, -250, -150.
REQ-022 Lock: pd alternating ±100 -> state SEARCH->ACQ after window 1; TRACK, gain_sel=2, locked=1 one clock after window 5.
REQ-023 Saturation: 16 samples of pd=-2^25 -> metric=2^25-1.
REQ-024 Loss: from TRACK, two windows at pd=400 -> HOLD, locked=0, gain_sel=1. A third window at 400 -> SEARCH, sweep=0. Repeat with the third window at pd=100 -> back to TRACK.
REQ-025 restart pulsed on the same cycle as a window completion -> no win_done, metric unchanged, state=SEARCH, sweep=0.
